// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver fed by a one-hot ring phase.
// Optional leading-zero blanking when LZ_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int SAT_W     = 8,
    parameter bit SEQ_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       phase,
    input  logic [15:0]      data_in,
    input  logic [3:0]       dp_in,
    input  logic             load,
    input  logic             clr_fault,
    output logic [3:0]       an_n,
    output logic [6:0]       seg_n,
    output logic             dp_n,
    output logic             pending,
    output logic             fault,
    output logic [SAT_W-1:0] fault_cnt
);

`ifdef LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    localparam logic [SAT_W-1:0] CNT_MAX = {SAT_W{1'b1}};
    localparam logic [SAT_W-1:0] CNT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

    logic [15:0] disp_data, pend_data, eff_data;
    logic [3:0]  disp_dp, pend_dp, eff_dp;
    logic [3:0]  prev;
    logic        prev_vld;
    logic        valid, frame_start, seq_bad, fault_now;
    logic [3:0]  nib;
    logic        sel_dp, blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign valid = (phase != 4'b0000) &&
                   ((phase & (phase - 4'd1)) == 4'b0000);
    assign frame_start = valid && (phase == 4'b1000);
    assign seq_bad = SEQ_CHECK && prev_vld && valid &&
                     (phase != {prev[0], prev[3:1]});
    assign fault_now = !valid || seq_bad;

    // Frame-start commit is visible to the same cycle's decode
    always_comb begin
        eff_data = disp_data;
        eff_dp   = disp_dp;
        if (frame_start) begin
            if (load) begin
                eff_data = data_in;
                eff_dp   = dp_in;
            end else if (pending) begin
                eff_data = pend_data;
                eff_dp   = pend_dp;
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        sel_dp = 1'b0;
        blank  = 1'b0;
        if (valid) begin
            unique case (1'b1)
                phase[0]: begin
                    nib    = eff_data[3:0];
                    sel_dp = eff_dp[0];
                end
                phase[1]: begin
                    nib    = eff_data[7:4];
                    sel_dp = eff_dp[1];
                    blank  = LZ && (eff_data[15:4] == 12'h000);
                end
                phase[2]: begin
                    nib    = eff_data[11:8];
                    sel_dp = eff_dp[2];
                    blank  = LZ && (eff_data[15:8] == 8'h00);
                end
                phase[3]: begin
                    nib    = eff_data[15:12];
                    sel_dp = eff_dp[3];
                    blank  = LZ && (eff_data[15:12] == 4'h0);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 4'b1111;
            seg_n <= 7'b1111111;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= valid ? ~phase : 4'b1111;
            seg_n <= (valid && !blank) ? hex7(nib) : 7'b1111111;
            dp_n  <= valid ? ~sel_dp : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data <= 16'h0000;
            disp_dp   <= 4'h0;
            pend_data <= 16'h0000;
            pend_dp   <= 4'h0;
            pending   <= 1'b0;
        end else begin
            disp_data <= eff_data;
            disp_dp   <= eff_dp;
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            if (frame_start)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 4'b0000;
            prev_vld <= 1'b0;
        end else begin
            prev_vld <= valid;
            if (valid)
                prev <= phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            if (fault_now)
                fault <= 1'b1;
            else if (clr_fault)
                fault <= 1'b0;
            if (fault_now && (fault_cnt != CNT_MAX))
                fault_cnt <= fault_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver.
// Runs a SEQ_CHECK=1 and a SEQ_CHECK=0 instance side by side.
`timescale 1ns/1ps
module tb_seg_scan_driver;

`ifdef LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  phase;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        clr_fault;
    logic [3:0]  an_n, an_n2;
    logic [6:0]  seg_n, seg_n2;
    logic        dp_n, dp_n2;
    logic        pending, pending2;
    logic        fault, fault2;
    logic [7:0]  fault_cnt, fault_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.SAT_W(8), .SEQ_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .phase(phase), .data_in(data_in),
        .dp_in(dp_in), .load(load), .clr_fault(clr_fault),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .pending(pending),
        .fault(fault), .fault_cnt(fault_cnt)
    );

    seg_scan_driver #(.SAT_W(8), .SEQ_CHECK(1'b0)) dut_noseq (
        .clk(clk), .rst_n(rst_n), .phase(phase), .data_in(data_in),
        .dp_in(dp_in), .load(load), .clr_fault(clr_fault),
        .an_n(an_n2), .seg_n(seg_n2), .dp_n(dp_n2), .pending(pending2),
        .fault(fault2), .fault_cnt(fault_cnt2)
    );

    task automatic cyc(input logic [3:0] p);
        phase = p;
        @(posedge clk);
        #1;
        load = 1'b0;
        clr_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; phase = 4'b0000; data_in = 16'h0;
        dp_in = 4'h0; load = 1'b0; clr_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an_n !== 4'b1111) begin errors++;
            $display("FAIL reset_an got %b exp 1111", an_n); end
        checks++;
        if (seg_n !== 7'b1111111) begin errors++;
            $display("FAIL reset_seg got %b exp 1111111", seg_n); end
        checks++;
        if (dp_n !== 1'b1) begin errors++;
            $display("FAIL reset_dp got %b exp 1", dp_n); end
        checks++;
        if ({pending, fault} !== 2'b00) begin errors++;
            $display("FAIL reset_flags got %b exp 00", {pending, fault}); end
        checks++;
        if (fault_cnt !== 8'd0) begin errors++;
            $display("FAIL reset_cnt got %0d exp 0", fault_cnt); end
        phase = 4'b1000;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] ph [4];
        ph = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            cyc(ph[i]);
            checks++;
            if (an_n !== ~ph[i]) begin errors++;
                $display("FAIL scan_an[%0d] got %b exp %b", i, an_n, ~ph[i]); end
            checks++;
            if (seg_n !== 7'b1000000) begin errors++;
                $display("FAIL scan_seg[%0d] got %b exp 1000000", i, seg_n); end
            checks++;
            if (fault !== 1'b0) begin errors++;
                $display("FAIL scan_fault[%0d] got %b exp 0", i, fault); end
        end
    endtask

    task automatic test_load();
        logic [3:0] ph [4];
        logic [6:0] es [4];
        logic [3:0] ea [4];
        logic       ed [4];
        ph = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        ea = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        es = '{7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110};
        ed = '{1'b1, 1'b1, 1'b0, 1'b1};
        cyc(4'b1000);
        data_in = 16'h1A8F; dp_in = 4'b0010; load = 1'b1;
        cyc(4'b0100);
        checks++;
        if (pending !== 1'b1) begin errors++;
            $display("FAIL load_pending got %b exp 1", pending); end
        cyc(4'b0010);
        checks++;
        if (seg_n !== 7'b1000000) begin errors++;
            $display("FAIL load_hold_seg got %b exp 1000000", seg_n); end
        cyc(4'b0001);
        checks++;
        if (dp_n !== 1'b1) begin errors++;
            $display("FAIL load_hold_dp got %b exp 1", dp_n); end
        for (int i = 0; i < 4; i++) begin
            cyc(ph[i]);
            checks++;
            if ({an_n, seg_n, dp_n} !== {ea[i], es[i], ed[i]}) begin errors++;
                $display("FAIL commit[%0d] got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                         i, an_n, seg_n, dp_n, ea[i], es[i], ed[i]); end
        end
        checks++;
        if (pending !== 1'b0) begin errors++;
            $display("FAIL commit_pending got %b exp 0", pending); end
    endtask

    task automatic test_frame_load();
        logic [3:0] ph [4];
        logic [6:0] es [4];
        logic [6:0] zb;
        ph = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        zb = LZ ? 7'b1111111 : 7'b1000000;
        es = '{zb, zb, 7'b0011001, 7'b0100100};
        data_in = 16'h0042; dp_in = 4'b0000; load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(ph[i]);
            if (i == 0) begin
                checks++;
                if (pending !== 1'b0) begin errors++;
                    $display("FAIL same_cycle_pending got %b exp 0", pending); end
            end
            checks++;
            if (seg_n !== es[i]) begin errors++;
                $display("FAIL h0042_seg[%0d] got %b exp %b", i, seg_n, es[i]); end
        end
        cyc(4'b1000);
        data_in = 16'hFFFF; dp_in = 4'b1111; load = 1'b1;
        cyc(4'b0100);
        data_in = 16'h0000; dp_in = 4'b0001; load = 1'b1;
        cyc(4'b0010);
        cyc(4'b0001);
        es = '{zb, zb, zb, 7'b1000000};
        for (int i = 0; i < 4; i++) begin
            cyc(ph[i]);
            checks++;
            if (seg_n !== es[i]) begin errors++;
                $display("FAIL h0000_seg[%0d] got %b exp %b", i, seg_n, es[i]); end
            checks++;
            if (dp_n !== (i != 3)) begin errors++;
                $display("FAIL h0000_dp[%0d] got %b exp %b", i, dp_n, (i != 3)); end
        end
    endtask

    task automatic test_invalid();
        for (int i = 1; i <= 3; i++) begin
            cyc(4'b0110);
            checks++;
            if ({an_n, seg_n, dp_n} !== 12'hFFF) begin errors++;
                $display("FAIL inv_out[%0d] got %b exp all ones", i, {an_n, seg_n, dp_n}); end
            checks++;
            if ({fault, fault_cnt} !== {1'b1, 8'(i)}) begin errors++;
                $display("FAIL inv_cnt[%0d] got f=%b c=%0d exp f=1 c=%0d",
                         i, fault, fault_cnt, i); end
        end
        clr_fault = 1'b1;
        cyc(4'b1000);
        checks++;
        if ({fault, fault_cnt} !== {1'b0, 8'd3}) begin errors++;
            $display("FAIL clr got f=%b c=%0d exp f=0 c=3", fault, fault_cnt); end
        checks++;
        if (an_n !== 4'b0111) begin errors++;
            $display("FAIL clr_an got %b exp 0111", an_n); end
        clr_fault = 1'b1;
        cyc(4'b0000);
        checks++;
        if ({fault, fault_cnt} !== {1'b1, 8'd4}) begin errors++;
            $display("FAIL clr_collide got f=%b c=%0d exp f=1 c=4", fault, fault_cnt); end
    endtask

    task automatic test_seq();
        rst_n = 1'b0;
        #1;
        phase = 4'b1000;
        rst_n = 1'b1;
        cyc(4'b1000);
        cyc(4'b0010);
        checks++;
        if ({fault, fault_cnt, an_n} !== {1'b1, 8'd1, 4'b1101}) begin errors++;
            $display("FAIL seq_skip got f=%b c=%0d an=%b exp f=1 c=1 an=1101",
                     fault, fault_cnt, an_n); end
        checks++;
        if ({fault2, fault_cnt2, an_n2} !== {1'b0, 8'd0, 4'b1101}) begin errors++;
            $display("FAIL noseq_skip got f=%b c=%0d an=%b exp f=0 c=0 an=1101",
                     fault2, fault_cnt2, an_n2); end
        cyc(4'b0001);
        checks++;
        if (fault_cnt !== 8'd1) begin errors++;
            $display("FAIL seq_resume got %0d exp 1", fault_cnt); end
        cyc(4'b0000);
        cyc(4'b0010);
        checks++;
        if (fault_cnt !== 8'd2) begin errors++;
            $display("FAIL seq_after_inv got %0d exp 2", fault_cnt); end
    endtask

    task automatic test_sat_reset();
        for (int i = 0; i < 300; i++) cyc(4'b0000);
        checks++;
        if ({fault, fault_cnt} !== {1'b1, 8'd255}) begin errors++;
            $display("FAIL sat got f=%b c=%0d exp f=1 c=255", fault, fault_cnt); end
        cyc(4'b1001);
        checks++;
        if (fault_cnt !== 8'd255) begin errors++;
            $display("FAIL sat_hold got %0d exp 255", fault_cnt); end
        data_in = 16'h1234; dp_in = 4'hF;
        cyc(4'b1000);
        load = 1'b1;
        cyc(4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an_n, fault_cnt, pending} !== {4'b1111, 8'd0, 1'b0}) begin errors++;
            $display("FAIL async_rst got an=%b c=%0d p=%b exp an=1111 c=0 p=0",
                     an_n, fault_cnt, pending); end
        @(posedge clk);
        #1;
        phase = 4'b1000;
        rst_n = 1'b1;
        cyc(4'b1000);
        checks++;
        if ({seg_n, dp_n} !== {(LZ ? 7'b1111111 : 7'b1000000), 1'b1}) begin errors++;
            $display("FAIL rst_discard got seg=%b dp=%b", seg_n, dp_n); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_frame_load();
        test_invalid();
        test_seq();
        test_sat_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
